fifo_wr_arbiter: RTL and testbench

Round-robin write scheduler that shares the single write port of the team's 8-entry FIFO between two producers. It grants ownership with a bounded burst length, drives the FIFO's write enable and data, and acknowledges each accepted word to its producer. Space checking uses the FIFO's data_count, so the FIFO never sees a write when it is full. The block sits between the producers and the FIFO top level. It replaces direct producer writes, so the FIFO's WR_ERROR path is never exercised in normal operation.

---
 rtl/fifo_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin scheduler sharing one FIFO write port between two producers
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [3:0]            fifo_data_count,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  ack0,
  output logic                  ack1,
  output logic [1:0]            owner,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  accept_cnt0,
  output logic [CNT_WIDTH-1:0]  accept_cnt1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_e;

  localparam logic [4:0] DEPTH5     = 5'(FIFO_DEPTH);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_e                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;
  logic [3:0]            burst_q, burst_d;
  logic                  ptr_q, ptr_d;

  logic                  space;
  logic                  cur_is1;
  logic                  cur_req;
  logic                  oth_req;
  logic [DATA_WIDTH-1:0] cur_din;
  state_e                oth_state;

  // The write already in flight has not reached data_count yet, so count it here.
  assign space = ({1'b0, fifo_data_count} + {4'b0, wr_en_q}) < DEPTH5;

  assign cur_is1   = (state_q == ST_OWN1);
  assign cur_req   = cur_is1 ? req1 : req0;
  assign oth_req   = cur_is1 ? req0 : req1;
  assign cur_din   = cur_is1 ? din1 : din0;
  assign oth_state = cur_is1 ? ST_OWN0 : ST_OWN1;

  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;
    din_d   = din_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    burst_d = burst_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = ptr_q ? ST_OWN1 : ST_OWN0;
        else if (req0)    state_d = ST_OWN0;
        else if (req1)    state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (cur_req) begin
          if (space) begin
            wr_en_d = 1'b1;
            din_d   = cur_din;
            if (cur_is1) begin
              ack1_d = 1'b1;
              cnt1_d = cnt1_q + CNT_WIDTH'(1);
            end else begin
              ack0_d = 1'b1;
              cnt0_d = cnt0_q + CNT_WIDTH'(1);
            end
            // A full burst only hands over when someone is actually waiting.
            if (burst_q == BURST_LAST) begin
              burst_d = 4'd0;
              if (oth_req) begin
                state_d = oth_state;
                ptr_d   = ~cur_is1;
              end
            end else begin
              burst_d = burst_q + 4'd1;
            end
          end
        end else begin
          state_d = oth_req ? oth_state : ST_IDLE;
          ptr_d   = ~cur_is1;
          burst_d = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      burst_q <= 4'd0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
    end
  end

  assign fifo_wr_en  = wr_en_q;
  assign fifo_din    = din_q;
  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign owner       = state_q;
  assign busy        = (state_q != ST_IDLE);
  assign accept_cnt0 = cnt0_q;
  assign accept_cnt1 = cnt1_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with randomized producers and FIFO model
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic [3:0]    fifo_data_count = 4'd0;
  logic          fifo_wr_en, ack0, ack1, busy;
  logic [DW-1:0] fifo_din;
  logic [1:0]    owner;
  logic [7:0]    accept_cnt0, accept_cnt1;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .MAX_BURST(MAXB), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .fifo_data_count(fifo_data_count),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .ack0(ack0), .ack1(ack1), .owner(owner), .busy(busy),
    .accept_cnt0(accept_cnt0), .accept_cnt1(accept_cnt1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] expq0[$];
  logic [DW-1:0] expq1[$];
  logic [7:0]    mcnt0 = 8'd0, mcnt1 = 8'd0;
  int            run0 = 0, run1 = 0;

  bit            has[2];
  logic [DW-1:0] word[2];
  int            words_left[2];
  int            gen_prob[2];
  int            rd_prob = 50;
  int            force_count = -1;
  int            occ = 0;
  bit            pend_w = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: runs on the falling edge, ahead of the driver which acts 1ns later.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("strobe", {fifo_wr_en, ack0 & ack1, busy, owner == 2'b11},
          {ack0 | ack1, 1'b0, owner != 2'b00, 1'b0});
      if (ack0) begin
        if (expq0.size() == 0) chk("unexpected_wr0", 64'd1, 64'd0);
        else chk("din0", fifo_din, expq0.pop_front());
        mcnt0 = mcnt0 + 8'd1;
        chk("accept_cnt0", accept_cnt0, mcnt0);
        if (expq1.size() != 0) run0++;
        chk("burst0", 64'(run0 <= MAXB), 64'd1);
        run1 = 0;
      end
      if (ack1) begin
        if (expq1.size() == 0) chk("unexpected_wr1", 64'd1, 64'd0);
        else chk("din1", fifo_din, expq1.pop_front());
        mcnt1 = mcnt1 + 8'd1;
        chk("accept_cnt1", accept_cnt1, mcnt1);
        if (expq0.size() != 0) run1++;
        chk("burst1", 64'(run1 <= MAXB), 64'd1);
        run0 = 0;
      end
    end
  end

  // One cycle of stimulus: FIFO occupancy model, then producers react to acks.
  task automatic step();
    bit a;
    @(negedge clk);
    #1;
    if (force_count >= 0) begin
      fifo_data_count = 4'(force_count);
    end else begin
      occ = occ + int'(pend_w);
      if (occ > 0 && $urandom_range(99) < rd_prob) occ--;
      chk("no_overflow", 64'(occ <= 8), 64'd1);
      fifo_data_count = 4'(occ);
    end
    pend_w = fifo_wr_en;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? ack0 : ack1;
      if (a) has[p] = 1'b0;
      if (!has[p] && words_left[p] > 0 && $urandom_range(99) < gen_prob[p]) begin
        has[p] = 1'b1;
        word[p] = $urandom;
        words_left[p]--;
        if (p == 0) expq0.push_back(word[p]);
        else expq1.push_back(word[p]);
      end
    end
    req0 = has[0];
    din0 = word[0];
    req1 = has[1];
    din1 = word[1];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", {fifo_wr_en, ack0, ack1, busy, owner, accept_cnt0, accept_cnt1},
        64'd0);
    chk("rst_din", fifo_din, 64'd0);
    for (int p = 0; p < 2; p++) begin
      has[p] = 1'b0;
      words_left[p] = 0;
      gen_prob[p] = 0;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    expq0.delete();
    expq1.delete();
    mcnt0 = 8'd0;
    mcnt1 = 8'd0;
    run0 = 0;
    run1 = 0;
    occ = 0;
    pend_w = 1'b0;
    force_count = 0;
    fifo_data_count = 4'd0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      has[p] = 1'b0;
      word[p] = '0;
      words_left[p] = 0;
      gen_prob[p] = 0;
    end
    repeat (2) @(negedge clk);
    do_reset();
    step();
    chk("idle_after_reset", owner, 64'd0);

    // Three words from producer 0 with an empty FIFO
    do_reset();
    words_left[0] = 3; gen_prob[0] = 100;
    step();
    step();
    chk("t2_owner", {owner, ack0}, {2'b01, 1'b0});
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("t2_ack", {ack0, fifo_wr_en}, 2'b11);
    end
    step();
    chk("t2_done", {ack0, accept_cnt0}, {1'b0, 8'd3});

    // Both producers continuously: bursts of MAXB alternate
    do_reset();
    words_left[0] = 1000; words_left[1] = 1000; gen_prob[0] = 100; gen_prob[1] = 100;
    step();
    step();
    chk("t3_owner", owner, 64'd1);
    for (int k = 2; k <= 17; k++) begin
      step();
      chk("t3_alternate", {ack1, ack0}, (((k - 2) / MAXB) % 2 == 0) ? 64'd1 : 64'd2);
    end

    // Space checking near full
    do_reset();
    force_count = 7; words_left[0] = 100; gen_prob[0] = 100;
    step();
    step();
    step();
    chk("t4_first_write", ack0, 64'd1);
    force_count = 8;
    step();
    chk("t4_stall7", ack0, 64'd0);
    step();
    chk("t4_stall8a", ack0, 64'd0);
    step();
    chk("t4_stall8b", ack0, 64'd0);
    force_count = 6;
    step();
    chk("t4_pre_resume", ack0, 64'd0);
    step();
    chk("t4_resume", ack0, 64'd1);
    step();
    chk("t4_resume2", ack0, 64'd1);

    // Producer 0 releases early while producer 1 waits
    do_reset();
    words_left[0] = 2; words_left[1] = 20; gen_prob[0] = 100; gen_prob[1] = 100;
    step();
    step();
    chk("t5_owner0", owner, 64'd1);
    step();
    chk("t5_ack_a", ack0, 64'd1);
    step();
    chk("t5_ack_b", ack0, 64'd1);
    step();
    chk("t5_switch", {owner, ack0, ack1}, {2'b10, 2'b00});
    step();
    chk("t5_ack1", ack1, 64'd1);

    // Lone producer 1 is never throttled
    do_reset();
    force_count = -1; rd_prob = 100;
    words_left[1] = 10; gen_prob[1] = 100;
    step();
    step();
    chk("t6_owner", {owner, ack1}, {2'b10, 1'b0});
    for (int k = 2; k <= 11; k++) begin
      step();
      chk("t6_back_to_back", {owner, ack1}, {2'b10, 1'b1});
    end
    step();
    chk("t6_done", {ack1, accept_cnt1}, {1'b0, 8'd10});

    // Randomized traffic with a reset in the middle
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      force_count = -1;
      words_left[0] = 100000; words_left[1] = 100000;
      for (int i = 0; i < 1500; i++) begin
        if (i % 150 == 0) begin
          gen_prob[0] = $urandom_range(100);
          gen_prob[1] = $urandom_range(100);
          rd_prob = $urandom_range(10, 100);
        end
        step();
      end
    end
    gen_prob[0] = 0; gen_prob[1] = 0; rd_prob = 100;
    for (int i = 0; i < 200 && (has[0] || has[1]); i++) step();
    chk("drained", {has[0], has[1], 8'(expq0.size()), 8'(expq1.size())}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
